// File: rtl/cmd_proc.sv
// Command processor: decodes UART commands into gyro calibration, tours and
// heading-aligned moves with a forward-speed ramp up/down profile.
module cmd_proc #(
    parameter int unsigned FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cal_done,
    input  logic        cntrIR,
    output logic        strt_cal,
    output logic        send_resp,
    output logic [7:0]  resp,
    output logic        moving,
    output logic [11:0] desired_heading,
    output logic [9:0]  frwrd,
    output logic        fanfare_go,
    output logic        tour_go
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned FRWRD_W = 10;
    localparam int unsigned HEAD_W  = 12;
    localparam int unsigned CNT_W   = 5;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] CAL     = 3'd1;
    localparam logic [STATE_W-1:0] TURN    = 3'd2;
    localparam logic [STATE_W-1:0] RAMP_UP = 3'd3;
    localparam logic [STATE_W-1:0] RAMP_DN = 3'd4;

    localparam logic [FRWRD_W-1:0] FRWRD_INC = (FAST_SIM != 0) ? 10'h020 : 10'h003;
    localparam logic [FRWRD_W-1:0] FRWRD_DEC = {FRWRD_INC[FRWRD_W-2:0], 1'b0};
    localparam logic [FRWRD_W-1:0] FRWRD_MAX = 10'h300;
    localparam logic [HEAD_W-1:0]  ALIGN_THR = 12'h02C;

    logic [STATE_W-1:0] state_q, state_d;
    logic [FRWRD_W-1:0] frwrd_q, frwrd_d;
    logic [HEAD_W-1:0]  desired_heading_q, desired_heading_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   sq_cnt_q, sq_cnt_d;
    logic               moving_q, moving_d;
    logic               fanfare_q, fanfare_d;
    logic               strt_cal_q, strt_cal_d;
    logic               send_resp_q, send_resp_d;
    logic               fanfare_go_q, fanfare_go_d;
    logic               tour_go_q, tour_go_d;
    logic               cntr_ir_q;

    logic [HEAD_W-1:0]  err;
    logic [HEAD_W-1:0]  err_abs;
    logic               aligned;
    logic               ir_rise;
    logic [FRWRD_W:0]   frwrd_sum;

    // Heading alignment and line-crossing detection
    always_comb begin
        err       = heading - desired_heading_q;
        err_abs   = err[HEAD_W-1] ? (~err + 12'd1) : err;
        aligned   = (err_abs < ALIGN_THR);
        ir_rise   = cntrIR & ~cntr_ir_q;
        frwrd_sum = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
    end

    // Next-state and output decode
    always_comb begin
        state_d           = state_q;
        frwrd_d           = frwrd_q;
        desired_heading_d = desired_heading_q;
        target_d          = target_q;
        sq_cnt_d          = (moving_q && ir_rise) ? (sq_cnt_q + 5'd1) : sq_cnt_q;
        moving_d          = moving_q;
        fanfare_d         = fanfare_q;
        strt_cal_d        = 1'b0;
        send_resp_d       = 1'b0;
        fanfare_go_d      = 1'b0;
        tour_go_d         = 1'b0;
        clr_cmd_rdy       = 1'b0;

        case (state_q)
            IDLE: begin
                frwrd_d = '0;
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    case (cmd[15:12])
                        4'b0000: begin
                            strt_cal_d = 1'b1;
                            state_d    = CAL;
                        end
                        4'b0010, 4'b0011: begin
                            desired_heading_d = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                            target_d          = {cmd[3:0], 1'b0};
                            sq_cnt_d          = '0;
                            fanfare_d         = cmd[12];
                            moving_d          = 1'b1;
                            state_d           = TURN;
                        end
                        4'b0100: tour_go_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            CAL: begin
                frwrd_d = '0;
                if (cal_done) begin
                    send_resp_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            TURN: begin
                frwrd_d = '0;
                if (aligned) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (heading_rdy)
                    frwrd_d = (frwrd_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : frwrd_sum[FRWRD_W-1:0];
                if (sq_cnt_q == target_q) state_d = RAMP_DN;
            end
            RAMP_DN: begin
                if (frwrd_q == '0) begin
                    moving_d     = 1'b0;
                    send_resp_d  = 1'b1;
                    fanfare_go_d = fanfare_q;
                    state_d      = IDLE;
                end else if (heading_rdy) begin
                    frwrd_d = (frwrd_q <= FRWRD_DEC) ? '0 : (frwrd_q - FRWRD_DEC);
                end
            end
            default: begin
                frwrd_d  = '0;
                moving_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            frwrd_q           <= '0;
            desired_heading_q <= '0;
            target_q          <= '0;
            sq_cnt_q          <= '0;
            moving_q          <= 1'b0;
            fanfare_q         <= 1'b0;
            strt_cal_q        <= 1'b0;
            send_resp_q       <= 1'b0;
            fanfare_go_q      <= 1'b0;
            tour_go_q         <= 1'b0;
            cntr_ir_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            frwrd_q           <= frwrd_d;
            desired_heading_q <= desired_heading_d;
            target_q          <= target_d;
            sq_cnt_q          <= sq_cnt_d;
            moving_q          <= moving_d;
            fanfare_q         <= fanfare_d;
            strt_cal_q        <= strt_cal_d;
            send_resp_q       <= send_resp_d;
            fanfare_go_q      <= fanfare_go_d;
            tour_go_q         <= tour_go_d;
            cntr_ir_q         <= cntrIR;
        end
    end

    assign strt_cal        = strt_cal_q;
    assign send_resp       = send_resp_q;
    assign resp            = 8'hA5;
    assign moving          = moving_q;
    assign desired_heading = desired_heading_q;
    assign frwrd           = frwrd_q;
    assign fanfare_go      = fanfare_go_q;
    assign tour_go         = tour_go_q;

endmodule

// File: tb/tb_cmd_proc.sv
// Self-checking bench for cmd_proc: directed scenarios plus randomized moves
// checked against a speed-profile model derived from the ramp rules.
module tb_cmd_proc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [11:0] heading;
    logic        heading_rdy;
    logic        cal_done;
    logic        cntrIR;
    logic        strt_cal;
    logic        send_resp;
    logic [7:0]  resp;
    logic        moving;
    logic [11:0] desired_heading;
    logic [9:0]  frwrd;
    logic        fanfare_go;
    logic        tour_go;

    cmd_proc #(.FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .heading(heading), .heading_rdy(heading_rdy),
        .cal_done(cal_done), .cntrIR(cntrIR), .strt_cal(strt_cal),
        .send_resp(send_resp), .resp(resp), .moving(moving),
        .desired_heading(desired_heading), .frwrd(frwrd),
        .fanfare_go(fanfare_go), .tour_go(tour_go)
    );

    always #5 clk = ~clk;

    localparam int INC  = 32;
    localparam int DEC  = 64;
    localparam int VMAX = 768;

    int checks = 0;
    int failures = 0;
    int n_send = 0, n_fan = 0, n_tour = 0, n_strt = 0, n_clr = 0, n_both = 0;
    int b_send, b_fan, b_tour, b_strt, b_clr, b_both;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (send_resp === 1'b1) n_send <= n_send + 1;
        if (fanfare_go === 1'b1) n_fan <= n_fan + 1;
        if (tour_go === 1'b1) n_tour <= n_tour + 1;
        if (strt_cal === 1'b1) n_strt <= n_strt + 1;
        if (clr_cmd_rdy === 1'b1) n_clr <= n_clr + 1;
        if (send_resp === 1'b1 && fanfare_go === 1'b1) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic hrdy();
        heading_rdy = 1'b1;
        tick();
        heading_rdy = 1'b0;
    endtask

    task automatic line_pulse();
        cntrIR = 1'b1;
        ticks(2);
        cntrIR = 1'b0;
        ticks(2);
    endtask

    task automatic send_cmd(input logic [15:0] c, input logic exp_clr);
        cmd     = c;
        cmd_rdy = 1'b1;
        @(negedge clk);
        chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(exp_clr));
        @(posedge clk);
        #1;
        cmd_rdy = 1'b0;
    endtask

    task automatic snap();
        b_send = n_send; b_fan = n_fan; b_tour = n_tour;
        b_strt = n_strt; b_clr = n_clr; b_both = n_both;
    endtask

    task automatic chk_pulses(input string tag, input int send, input int fan,
                              input int tour, input int strt);
        chk({tag, "_send_resp"}, 32'(n_send - b_send), 32'(send));
        chk({tag, "_fanfare_go"}, 32'(n_fan - b_fan), 32'(fan));
        chk({tag, "_tour_go"}, 32'(n_tour - b_tour), 32'(tour));
        chk({tag, "_strt_cal"}, 32'(n_strt - b_strt), 32'(strt));
    endtask

    function automatic int ramp_up_speed(input int strobes);
        return (strobes * INC > VMAX) ? VMAX : strobes * INC;
    endfunction

    function automatic int ramp_dn_speed(input int peak, input int strobes);
        return (peak - strobes * DEC < 0) ? 0 : peak - strobes * DEC;
    endfunction

    initial begin
        logic [7:0]  h;
        logic [3:0]  s;
        logic        f;
        logic [11:0] exp_dh;
        int          k, off, peak, n_dn;

        rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; heading = '0;
        heading_rdy = 1'b0; cal_done = 1'b0; cntrIR = 1'b0;
        ticks(2);
        chk("rst_frwrd", 32'(frwrd), 32'h0);
        chk("rst_desired", 32'(desired_heading), 32'h0);
        chk("rst_moving", 32'(moving), 32'h0);
        chk("rst_pulses", 32'({strt_cal, send_resp, fanfare_go, tour_go}), 32'h0);
        chk("resp", 32'(resp), 32'hA5);
        rst_n = 1'b1;
        ticks(2);

        // Calibration
        snap();
        send_cmd(16'h0000, 1'b1);
        chk("cal_strt_cal", 32'(strt_cal), 32'h1);
        ticks(4);
        chk("cal_wait_send", 32'(n_send - b_send), 32'h0);
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        ticks(3);
        chk_pulses("cal", 1, 0, 0, 1);
        chk("cal_resp", 32'(resp), 32'hA5);

        // Plain move, target 4
        snap();
        heading = 12'h000;
        send_cmd(16'h2002, 1'b1);
        chk("mv_desired", 32'(desired_heading), 32'h000);
        chk("mv_moving", 32'(moving), 32'h1);
        tick();
        for (int i = 0; i < 3; i++) hrdy();
        chk("mv_frwrd_up", 32'(frwrd), 32'h060);
        for (int i = 0; i < 4; i++) line_pulse();
        chk("mv_frwrd_hold", 32'(frwrd), 32'h060);
        hrdy();
        chk("mv_frwrd_dn1", 32'(frwrd), 32'h020);
        hrdy();
        chk("mv_frwrd_dn2", 32'(frwrd), 32'h000);
        ticks(3);
        chk_pulses("mv", 1, 0, 0, 0);
        chk("mv_moving_end", 32'(moving), 32'h0);

        // Fanfare move, turn held until aligned
        snap();
        heading = 12'h000;
        send_cmd(16'h33F1, 1'b1);
        chk("ff_desired", 32'(desired_heading), 32'h3FF);
        for (int i = 0; i < 4; i++) hrdy();
        chk("ff_turn_frwrd", 32'(frwrd), 32'h000);
        chk("ff_turn_moving", 32'(moving), 32'h1);
        heading = 12'h3F0;
        tick();
        hrdy();
        chk("ff_frwrd_up", 32'(frwrd), 32'h020);
        for (int i = 0; i < 2; i++) line_pulse();
        hrdy();
        chk("ff_frwrd_dn", 32'(frwrd), 32'h000);
        ticks(3);
        chk_pulses("ff", 1, 1, 0, 0);
        chk("ff_same_cycle", 32'(n_both - b_both), 32'h1);
        chk("ff_moving_end", 32'(moving), 32'h0);

        // Alignment threshold edges, cmd ignored mid-ramp, then reset abort
        snap();
        heading = 12'h02C;
        send_cmd(16'h2001, 1'b1);
        for (int i = 0; i < 3; i++) hrdy();
        chk("thr_pos44_frwrd", 32'(frwrd), 32'h000);
        heading = 12'hFD4;
        for (int i = 0; i < 3; i++) hrdy();
        chk("thr_neg44_frwrd", 32'(frwrd), 32'h000);
        heading = 12'hFD5;
        tick();
        hrdy();
        hrdy();
        chk("thr_neg43_frwrd", 32'(frwrd), 32'h040);
        snap();
        cmd = 16'h0000;
        cmd_rdy = 1'b1;
        ticks(5);
        chk("busy_no_clr", 32'(n_clr - b_clr), 32'h0);
        chk("busy_frwrd", 32'(frwrd), 32'h040);
        cmd_rdy = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("abort_frwrd", 32'(frwrd), 32'h000);
        chk("abort_moving", 32'(moving), 32'h0);
        tick();
        rst_n = 1'b1;
        ticks(4);
        chk_pulses("abort", 0, 0, 0, 0);
        chk("abort_desired", 32'(desired_heading), 32'h000);

        // Zero-square move completes without lines
        snap();
        heading = 12'h01F;
        send_cmd(16'h2010, 1'b1);
        chk("zero_desired", 32'(desired_heading), 32'h01F);
        ticks(5);
        chk_pulses("zero", 1, 0, 0, 0);
        chk("zero_moving", 32'(moving), 32'h0);
        chk("zero_frwrd", 32'(frwrd), 32'h000);

        // Tour and unused opcode
        snap();
        send_cmd(16'h4000, 1'b1);
        ticks(2);
        chk_pulses("tour", 0, 0, 1, 0);
        snap();
        send_cmd(16'hF123, 1'b1);
        ticks(3);
        chk_pulses("nop", 0, 0, 0, 0);
        chk("nop_moving", 32'(moving), 32'h0);

        // Randomized moves against the speed-profile model
        for (int it = 0; it < 8; it++) begin
            h      = 8'($urandom_range(0, 255));
            s      = 4'($urandom_range(1, 5));
            f      = 1'($urandom_range(0, 1));
            k      = (it == 0) ? 28 : int'($urandom_range(0, 30));
            exp_dh = (h == 8'h00) ? 12'h000 : {h, 4'hF};
            off    = int'($urandom_range(0, 86)) - 43;
            heading = exp_dh + 12'(off);
            snap();
            send_cmd({3'b001, f, h, s}, 1'b1);
            chk("rnd_desired", 32'(desired_heading), 32'(exp_dh));
            tick();
            for (int j = 0; j < k; j++) hrdy();
            peak = ramp_up_speed(k);
            chk("rnd_peak", 32'(frwrd), 32'(peak));
            for (int j = 0; j < 2 * int'(s); j++) line_pulse();
            n_dn = (peak + DEC - 1) / DEC;
            for (int j = 1; j <= n_dn; j++) begin
                hrdy();
                chk("rnd_ramp_dn", 32'(frwrd), 32'(ramp_dn_speed(peak, j)));
            end
            ticks(3);
            chk_pulses("rnd_end", 1, int'(f), 0, 0);
            chk("rnd_moving", 32'(moving), 32'h0);

            snap();
            send_cmd({4'($urandom_range(5, 15)), 12'($urandom)}, 1'b1);
            ticks(3);
            chk_pulses("rnd_nop", 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
